sqrt_seq: RTL and testbench
===========================

Name: sqrt_seq

Overview:
Parametrised, iterative integer square root. It generalises the team's fixed-width combinational sqrt_128b into a clocked, multi-cycle unit with valid/ready handshakes, a configurable operand width, and configurable root bits resolved per cycle. It also returns the remainder. It sits in the benchmark-circuit set as the sequential counterpart for area/latency trade-off studies and is driven by dataset-file benches.

Parameters:
- WIDTH, 128: radicand width. Must be even and ≥ 4.
- BITS_PER_CYCLE, 1: root bits resolved per clock. Must divide WIDTH/2.
- Derived, N = (WIDTH/2)/BITS_PER_CYCLE: iteration cycles per operation.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  radicand presented
- in_ready  out  1  unit can accept a radicand
- in_data  in  WIDTH  unsigned radicand
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_root  out  WIDTH/2  floor(sqrt(in_data))
- out_rem  out  WIDTH/2+1  in_data − out_root²
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset: synchronous, active-high. On any clk edge with rst=1:
  - state←IDLE
  - out_valid=0, in_ready=1 (from the following cycle), busy=0
  - out_root=0, out_rem=0, iteration counter=0
  - rst overrides all other inputs.
- States:
  - IDLE: in_ready=1.
    - On in_valid&&in_ready: latch in_data into the shift register, clear the root and remainder accumulators, counter←0, go to CALC.
  - CALC: in_ready=0. Each cycle performs BITS_PER_CYCLE chained restoring steps. Per step:
    - rem ← (rem<<2) | top 2 bits of the radicand shift register; shift the radicand left by 2.
    - trial ← (root<<2) | 1.
    - If rem ≥ trial: rem −= trial and root ← (root<<1)|1. Otherwise root ← root<<1.
    - After step group N−1: go to DONE.
  - DONE: out_valid=1. out_root and out_rem hold stable while out_valid && !out_ready.
    - On out_ready: go to IDLE.
- Latency: out_valid rises exactly N cycles after the accept edge. With the defaults this is 64 cycles.
- Throughput: one result per N+2 cycles (accept, N iterations, handshake). There is no overlap.
- Inputs ignored outside IDLE:
  - in_valid is ignored while busy.
  - in_data needs to be valid only on the accept edge.
- Outputs in IDLE/CALC: out_root and out_rem keep the last delivered result (0 after reset). They are qualified only by out_valid.
- Width rules:
  - The accumulator rem is WIDTH/2+2 bits internally to hold the trial compare without overflow.
  - out_rem is WIDTH/2+1 bits, because the maximum remainder is 2·root ≤ 2^(WIDTH/2+1)−2.
  - All arithmetic is unsigned.
- Boundaries:
  - in_data=0 gives root 0, rem 0.
  - in_data=2^WIDTH−1 gives all-ones root, rem=2^(WIDTH/2+1)−2.
  - out_ready held high before DONE: the result is accepted on the first DONE cycle, so out_valid is high for exactly 1 cycle.
- Reset mid-operation: rst during CALC or DONE aborts. No out_valid pulse is produced for the aborted operand.

Decomposition:
- Package sqrt_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - localparams for the root width (WIDTH/2), rem width (WIDTH/2+1) and internal accumulator width (WIDTH/2+2), derived from WIDTH;
  - the function that computes N.
- Sub-module sqrt_step: one combinational restoring step (rem, root, 2 radicand bits in; rem, root out). Instantiate it BITS_PER_CYCLE times in a generate chain inside sqrt_seq.
- The top level holds the FSM, counter, shift register and output registers.

Test Plan:
1. Defaults. Accept in_data=144 with out_ready=1 → out_valid exactly 64 cycles after the accept edge; out_root=12, out_rem=0; then in_ready=1 the next cycle.
2. Defaults. in_data=145, then in_data=0 back-to-back → results (12,1) then (0,0); in_valid asserted during CALC is ignored and in_ready=0 throughout CALC.
3. Defaults. in_data=2^128−1 → out_root=0xFFFF_FFFF_FFFF_FFFF, out_rem=0x1_FFFF_FFFF_FFFF_FFFE.
4. Backpressure. out_ready=0 for 10 cycles after DONE → out_valid and outputs hold stable; the result is consumed on the first cycle out_ready=1, then IDLE.
5. Reset mid-op. Assert rst for 1 cycle at iteration 30 → out_valid never pulses, in_ready=1 the next cycle, outputs 0; a fresh in_data=1,000,000 then yields root 1000, rem 0.
6. WIDTH=16, BITS_PER_CYCLE=2 (N=4). in_data=65535 → root 255, rem 510 after 4 cycles. Random sweep of 10,000 values checked against a floor-sqrt reference model.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential integer square root.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 128;

    // Root width for a given radicand width.
    function automatic int unsigned root_w(input int unsigned width);
        return width / 2;
    endfunction

    // Delivered remainder width: max remainder is 2*root.
    function automatic int unsigned rem_w(input int unsigned width);
        return width / 2 + 1;
    endfunction

    // Trial-compare width inside one restoring step.
    function automatic int unsigned acc_w(input int unsigned width);
        return width / 2 + 2;
    endfunction

    // Iteration cycles per operation.
    function automatic int unsigned calc_n(input int unsigned width,
                                           input int unsigned bits_per_cycle);
        return (width / 2) / bits_per_cycle;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root step: resolves a single root bit.
module sqrt_step #(
    parameter int unsigned RW = 64
) (
    input  logic [RW:0]   rem_i,
    input  logic [RW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [RW:0]   rem_o,
    output logic [RW-1:0] root_o
);

    logic [RW+1:0] rem_sh;
    logic [RW+1:0] trial;
    logic          ge;

    // Bring in two radicand bits, compare against (root<<2)|1 and restore.
    // The difference is taken at RW+1 bits: when ge holds it is at most
    // 2*root, so the dropped top bit is always zero.
    always_comb begin
        rem_sh = {rem_i, bits_i};
        trial  = {root_i, 2'b01};
        ge     = (rem_sh >= trial);
        root_o = {root_i[RW-2:0], ge};
        rem_o  = ge ? (rem_sh[RW:0] - trial[RW:0]) : rem_sh[RW:0];
    end

endmodule

// File: rtl/sqrt_seq.sv
// Iterative integer square root with remainder and valid/ready handshakes.
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] out_root,
    output logic [WIDTH/2:0]   out_rem,
    output logic               busy
);

    localparam int unsigned RW    = root_w(WIDTH);
    localparam int unsigned REM_W = rem_w(WIDTH);
    localparam int unsigned N     = calc_n(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rad_q, rad_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [RW-1:0]      root_q, root_d;
    logic [RW-1:0]      out_root_q, out_root_d;
    logic [REM_W-1:0]   out_rem_q, out_rem_d;

    logic [REM_W-1:0]   rem_c  [BITS_PER_CYCLE+1];
    logic [RW-1:0]      root_c [BITS_PER_CYCLE+1];

    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        sqrt_step #(.RW(RW)) u_step (
            .rem_i  (rem_c[g]),
            .root_i (root_c[g]),
            .bits_i (rad_q[WIDTH-1-2*g -: 2]),
            .rem_o  (rem_c[g+1]),
            .root_o (root_c[g+1])
        );
    end

    // State, datapath and result registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            out_root_q <= '0;
            out_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            out_root_q <= out_root_d;
            out_rem_q  <= out_rem_d;
        end
    end

    // Next-state and datapath update; results are captured only on the last
    // step group so the outputs keep the previous result during CALC.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        out_root_d = out_root_q;
        out_rem_d  = out_rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rad_d   = in_data;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rad_d  = rad_q << (2 * BITS_PER_CYCLE);
                rem_d  = rem_c[BITS_PER_CYCLE];
                root_d = root_c[BITS_PER_CYCLE];
                if (cnt_q == CNT_W'(N - 1)) begin
                    out_root_d = root_c[BITS_PER_CYCLE];
                    out_rem_d  = rem_c[BITS_PER_CYCLE];
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Scoreboard bench for sqrt_seq: default 128-bit instance and a 16-bit/2-bit instance.
module tb_sqrt_seq;

    localparam int unsigned N128 = 64;
    localparam int unsigned N16  = 4;

    typedef struct {
        logic [63:0] root;
        logic [64:0] rem;
        int unsigned acc;
    } exp128_t;

    typedef struct {
        logic [7:0]  root;
        logic [8:0]  rem;
        int unsigned acc;
    } exp16_t;

    logic         clk = 1'b0;
    logic         rst;
    int unsigned  cyc = 0;
    int unsigned  n_chk = 0;
    int unsigned  n_fail = 0;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data;
    logic [63:0]  out_root;
    logic [64:0]  out_rem;

    logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0]  in_data16;
    logic [7:0]   out_root16;
    logic [8:0]   out_rem16;

    exp128_t q[$];
    exp16_t  q16[$];

    sqrt_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_root(out_root), .out_rem(out_rem), .busy(busy)
    );

    sqrt_seq #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_root(out_root16), .out_rem(out_rem16), .busy(busy16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [129:0] got, input logic [129:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference floor-sqrt via real arithmetic with integer correction.
    function automatic int unsigned isqrt(input int unsigned x);
        int unsigned r;
        r = int'($floor($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Monitor for the 128-bit instance.
    always begin : mon128
        bit v_prev = 1'b0;
        exp128_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 130'(out_valid), 130'(0));
                end else begin
                    e = q[0];
                    if (!v_prev) check("latency128", 130'(cyc - e.acc), 130'(N128));
                    check("result128", {out_root, out_rem}, {e.root, e.rem});
                    if (out_ready) void'(q.pop_front());
                end
            end
            v_prev = out_valid && !rst;
        end
    end

    // Monitor for the 16-bit instance.
    always begin : mon16
        bit v_prev = 1'b0;
        exp16_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid16) begin
                if (q16.size() == 0) begin
                    check("unexpected_out_valid16", 130'(out_valid16), 130'(0));
                end else begin
                    e = q16[0];
                    if (!v_prev) check("latency16", 130'(cyc - e.acc), 130'(N16));
                    check("result16", 130'({out_root16, out_rem16}), 130'({e.root, e.rem}));
                    if (out_ready16) void'(q16.pop_front());
                end
            end
            v_prev = out_valid16 && !rst;
        end
    end

    task automatic issue(input logic [127:0] x, input bit push, input logic [63:0] r, input logic [64:0] m);
        int unsigned k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("issue_ready128", 130'(in_ready), 130'(1));
        in_valid = 1'b1;
        in_data  = x;
        if (push) q.push_back('{r, m, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain();
        int unsigned k = 0;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("drain128", 130'(q.size()), 130'(0));
    endtask

    task automatic issue16(input logic [15:0] x, input logic [7:0] r, input logic [8:0] m);
        int unsigned k = 0;
        @(negedge clk);
        while (!in_ready16 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready16) check("issue_ready16", 130'(in_ready16), 130'(1));
        in_valid16 = 1'b1;
        in_data16  = x;
        q16.push_back('{r, m, cyc + 1});
        @(negedge clk);
        in_valid16 = 1'b0;
        k = 0;
        while (q16.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        if (q16.size() != 0) check("drain16", 130'(q16.size()), 130'(0));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] x;
        logic [7:0]  r;
        logic [8:0]  m;
    } vec16_t;

    initial begin : stim
        int unsigned k;
        int unsigned bad;
        int unsigned x;
        int unsigned r;
        vec16_t v16[9];
        v16 = '{'{16'd0, 8'd0, 9'd0}, '{16'd1, 8'd1, 9'd0}, '{16'd2, 8'd1, 9'd1},
                '{16'd3, 8'd1, 9'd2}, '{16'd4, 8'd2, 9'd0}, '{16'd65535, 8'd255, 9'd510},
                '{16'd65025, 8'd255, 9'd0}, '{16'd65024, 8'd254, 9'd508},
                '{16'd1000, 8'd31, 9'd39}};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 130'(in_ready), 130'(1));
        check("reset_out_valid", 130'(out_valid), 130'(0));
        check("reset_busy", 130'(busy), 130'(0));
        check("reset_outputs", {out_root, out_rem}, 130'(0));

        // 1: 144 with out_ready high; result for exactly one cycle
        issue(128'd144, 1'b1, 64'd12, 65'd0);
        drain();
        @(negedge clk);
        check("t1_in_ready_after", 130'(in_ready), 130'(1));
        check("t1_out_valid_after", 130'(out_valid), 130'(0));

        // 2: 145 then 0 back-to-back, in_valid held through CALC
        @(negedge clk);
        check("t2_ready", 130'(in_ready), 130'(1));
        in_valid = 1'b1;
        in_data  = 128'd145;
        q.push_back('{64'd12, 65'd1, cyc + 1});
        @(negedge clk);
        in_data = 128'd99;
        bad = 0;
        k = 0;
        while (!out_valid && k < 200) begin
            if (in_ready || !busy) bad++;
            @(negedge clk);
            k++;
        end
        check("t2_calc_timeout", 130'(out_valid), 130'(1));
        check("t2_calc_in_ready_low", 130'(bad), 130'(0));
        in_data = 128'd0;
        @(negedge clk);
        check("t2_ready_second", 130'(in_ready), 130'(1));
        q.push_back('{64'd0, 65'd0, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // 3: all-ones radicand
        issue({128{1'b1}}, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE);
        drain();

        // 4: backpressure for 10 cycles
        @(negedge clk);
        out_ready = 1'b0;
        issue(128'd200, 1'b1, 64'd14, 65'd4);
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_valid_timeout", 130'(out_valid), 130'(1));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid) bad++;
        end
        check("t4_valid_held", 130'(bad), 130'(0));
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_dropped", 130'(out_valid), 130'(0));
        check("t4_in_ready", 130'(in_ready), 130'(1));
        drain();

        // 5: reset at iteration 30 aborts the operation
        issue(128'd12345, 1'b0, '0, '0);
        repeat (29) @(negedge clk);
        check("t5_busy_before_rst", 130'(busy), 130'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_in_ready", 130'(in_ready), 130'(1));
        check("t5_out_valid", 130'(out_valid), 130'(0));
        check("t5_busy", 130'(busy), 130'(0));
        check("t5_outputs_zero", {out_root, out_rem}, 130'(0));
        issue(128'd1_000_000, 1'b1, 64'd1000, 65'd0);
        drain();

        // 6: 16-bit instance, directed vectors then reference sweep
        foreach (v16[i]) issue16(v16[i].x, v16[i].r, v16[i].m);
        for (int i = 0; i < 10000; i++) begin
            x = $urandom_range(0, 65535);
            r = isqrt(x);
            issue16(x[15:0], r[7:0], 9'(x - r * r));
        end

        repeat (5) @(negedge clk);
        check("final_queue128", 130'(q.size()), 130'(0));
        check("final_queue16", 130'(q16.size()), 130'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
